// File: rtl/load_rsv_station.sv
// rtl/load_rsv_station.sv - in-order load reservation station with CDB snoop
// Optional same-cycle CDB-to-issue forwarding: LOAD_RSV_CDB_FORWARD_EN
module load_rsv_station #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               dispatch_valid,
    output logic               dispatch_ready,
    input  logic [2:0]         dispatch_width,
    input  logic [5:0]         dispatch_dest,
    input  logic               dispatch_opr1_rdy,
    input  logic [31:0]        dispatch_opr1,
    input  logic               dispatch_opr2_rdy,
    input  logic [31:0]        dispatch_opr2,
    input  logic [31:0]        dispatch_offset,
    input  logic [37:0]        cdb,
    input  logic               issue_stall,
    output logic               enable,
    output logic [104:0]       rs2exe,
    output logic [PTR_W:0]     occupancy
);

    typedef struct packed {
        logic        valid;
        logic [2:0]  width;
        logic [5:0]  dest;
        logic        opr1_rdy;
        logic [31:0] opr1;
        logic        opr2_rdy;
        logic [31:0] opr2;
        logic [31:0] offset;
    } entry_t;

    entry_t            ent_q [DEPTH];
    entry_t            ent_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W:0]    count_q, count_d;

    logic [5:0]        cdb_tag;
    logic [31:0]       cdb_data;
    entry_t            head_ent;
    logic              head_rdy1, head_rdy2, head_ready;
    logic [31:0]       head_opr1, head_opr2;
    logic              do_disp;

    // Tag 0 is the idle CDB encoding and must never wake an operand.
    function automatic logic tag_match(input logic [5:0] tag, input logic [31:0] opr);
        return (tag != 6'd0) && (tag == opr[5:0]);
    endfunction

    assign cdb_tag        = cdb[37:32];
    assign cdb_data       = cdb[31:0];
    assign head_ent       = ent_q[head_q];
    assign dispatch_ready = (count_q != (PTR_W+1)'(DEPTH));
    assign occupancy      = count_q;
    assign do_disp        = dispatch_valid && dispatch_ready && !flush;

`ifdef LOAD_RSV_CDB_FORWARD_EN
    logic fwd1, fwd2;
    assign fwd1      = !head_ent.opr1_rdy && tag_match(cdb_tag, head_ent.opr1);
    assign fwd2      = !head_ent.opr2_rdy && tag_match(cdb_tag, head_ent.opr2);
    assign head_rdy1 = head_ent.opr1_rdy || fwd1;
    assign head_rdy2 = head_ent.opr2_rdy || fwd2;
    assign head_opr1 = fwd1 ? cdb_data : head_ent.opr1;
    assign head_opr2 = fwd2 ? cdb_data : head_ent.opr2;
`else
    assign head_rdy1 = head_ent.opr1_rdy;
    assign head_rdy2 = head_ent.opr2_rdy;
    assign head_opr1 = head_ent.opr1;
    assign head_opr2 = head_ent.opr2;
`endif

    assign head_ready = head_ent.valid && head_rdy1 && head_rdy2;
    assign enable     = head_ready && !issue_stall && !flush;
    assign rs2exe     = head_ent.valid
                        ? {head_ent.width, head_ent.dest, head_opr1, head_opr2, head_ent.offset}
                        : 105'd0;

    always_comb begin
        ent_d   = ent_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid && !ent_q[i].opr1_rdy && tag_match(cdb_tag, ent_q[i].opr1)) begin
                ent_d[i].opr1     = cdb_data;
                ent_d[i].opr1_rdy = 1'b1;
            end
            if (ent_q[i].valid && !ent_q[i].opr2_rdy && tag_match(cdb_tag, ent_q[i].opr2)) begin
                ent_d[i].opr2     = cdb_data;
                ent_d[i].opr2_rdy = 1'b1;
            end
        end

        if (enable) begin
            ent_d[head_q].valid = 1'b0;
            head_d              = head_q + PTR_W'(1);
        end

        // The incoming entry sees the same broadcast as the resident ones.
        if (do_disp) begin
            ent_d[tail_q].valid    = 1'b1;
            ent_d[tail_q].width    = dispatch_width;
            ent_d[tail_q].dest     = dispatch_dest;
            ent_d[tail_q].offset   = dispatch_offset;
            ent_d[tail_q].opr1_rdy = dispatch_opr1_rdy || tag_match(cdb_tag, dispatch_opr1);
            ent_d[tail_q].opr1     = (!dispatch_opr1_rdy && tag_match(cdb_tag, dispatch_opr1))
                                     ? cdb_data : dispatch_opr1;
            ent_d[tail_q].opr2_rdy = dispatch_opr2_rdy || tag_match(cdb_tag, dispatch_opr2);
            ent_d[tail_q].opr2     = (!dispatch_opr2_rdy && tag_match(cdb_tag, dispatch_opr2))
                                     ? cdb_data : dispatch_opr2;
            tail_d                 = tail_q + PTR_W'(1);
        end

        count_d = count_q + (PTR_W+1)'(do_disp) - (PTR_W+1)'(enable);

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_load_rsv_station.sv
// tb/tb_load_rsv_station.sv - scoreboard bench for load_rsv_station
module tb_load_rsv_station;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           flush;
    logic           dispatch_valid;
    logic           dispatch_ready;
    logic [2:0]     dispatch_width;
    logic [5:0]     dispatch_dest;
    logic           dispatch_opr1_rdy;
    logic [31:0]    dispatch_opr1;
    logic           dispatch_opr2_rdy;
    logic [31:0]    dispatch_opr2;
    logic [31:0]    dispatch_offset;
    logic [37:0]    cdb;
    logic           issue_stall;
    logic           enable;
    logic [104:0]   rs2exe;
    logic [PTR_W:0] occupancy;

    load_rsv_station #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .dispatch_valid    (dispatch_valid),
        .dispatch_ready    (dispatch_ready),
        .dispatch_width    (dispatch_width),
        .dispatch_dest     (dispatch_dest),
        .dispatch_opr1_rdy (dispatch_opr1_rdy),
        .dispatch_opr1     (dispatch_opr1),
        .dispatch_opr2_rdy (dispatch_opr2_rdy),
        .dispatch_opr2     (dispatch_opr2),
        .dispatch_offset   (dispatch_offset),
        .cdb               (cdb),
        .issue_stall       (issue_stall),
        .enable            (enable),
        .rs2exe            (rs2exe),
        .occupancy         (occupancy)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [104:0] sb[$];
    logic         en_s;

    task automatic check(input string tag, input logic [104:0] got, input logic [104:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [104:0] pk(input logic [2:0] w, input logic [5:0] d,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] off);
        return {w, d, a, b, off};
    endfunction

    // One cycle: sample outputs mid-cycle, score any issue, then cross the edge.
    task automatic step();
        logic [104:0] e;
        @(negedge clk);
        en_s = enable;
        if (enable) begin
            if (sb.size() == 0) check("unexpected_issue", 105'(1), 105'(0));
            else begin
                e = sb.pop_front();
                check("issue_bundle", rs2exe, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [2:0] w, input logic [5:0] d,
                        input logic r1, input logic [31:0] o1,
                        input logic r2, input logic [31:0] o2, input logic [31:0] off);
        dispatch_valid    = 1'b1;
        dispatch_width    = w;
        dispatch_dest     = d;
        dispatch_opr1_rdy = r1;
        dispatch_opr1     = o1;
        dispatch_opr2_rdy = r2;
        dispatch_opr2     = o2;
        dispatch_offset   = off;
        step();
        dispatch_valid    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; dispatch_valid = 1'b0;
        dispatch_width = '0; dispatch_dest = '0; dispatch_opr1_rdy = 1'b0; dispatch_opr1 = '0;
        dispatch_opr2_rdy = 1'b0; dispatch_opr2 = '0; dispatch_offset = '0;
        cdb = '0; issue_stall = 1'b0;
        @(posedge clk); #1;
        check("rst_enable",    105'(enable),         105'(0));
        check("rst_rs2exe",    rs2exe,               105'(0));
        check("rst_occupancy", 105'(occupancy),      105'(0));
        check("rst_ready",     105'(dispatch_ready), 105'(1));
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset mid-operation: three stalled ready entries, reset lands with stall released
        issue_stall = 1'b1;
        for (int i = 0; i < 3; i++) disp(3'b010, 6'(1 + i), 1'b1, 32'h100, 1'b1, 32'h0, 32'h0);
        check("t1_occ_before", 105'(occupancy), 105'(3));
        reset = 1'b1; issue_stall = 1'b0;
        #1;
        check("t1_async_enable", 105'(enable),         105'(0));
        check("t1_async_occ",    105'(occupancy),      105'(0));
        check("t1_async_ready",  105'(dispatch_ready), 105'(1));
        @(posedge clk); #1;
        reset = 1'b0;

        // Ready dispatch issues one cycle later
        sb.push_back(pk(3'b010, 6'd5, 32'h1000, 32'h24, 32'h10));
        disp(3'b010, 6'd5, 1'b1, 32'h1000, 1'b1, 32'h24, 32'h10);
        check("t2_no_same_cycle", 105'(en_s), 105'(0));
        step();
        check("t2_enable", 105'(en_s),      105'(1));
        check("t2_occ",    105'(occupancy), 105'(0));

        // CDB wakeup on opr1 tag 9
        sb.push_back(pk(3'b001, 6'd6, 32'h2000, 32'h4, 32'hFFFF_FFF0));
        disp(3'b001, 6'd6, 1'b0, 32'h9, 1'b1, 32'h4, 32'hFFFF_FFF0);
        step(); check("t3_wait0", 105'(en_s), 105'(0));
        step(); check("t3_wait1", 105'(en_s), 105'(0));
        cdb = {6'd9, 32'h2000};
        step();
`ifdef LOAD_RSV_CDB_FORWARD_EN
        check("t3_fwd_issue", 105'(en_s), 105'(1));
        cdb = '0;
`else
        check("t3_cdb_cycle", 105'(en_s), 105'(0));
        cdb = '0;
        step(); check("t3_issue", 105'(en_s), 105'(1));
`endif
        check("t3_occ", 105'(occupancy), 105'(0));

        // In-order: blocked A holds back ready B
        sb.push_back(pk(3'b010, 6'd11, 32'h7777, 32'h8, 32'h0));
        sb.push_back(pk(3'b100, 6'd12, 32'h300, 32'h0, 32'h4));
        disp(3'b010, 6'd11, 1'b0, 32'h7, 1'b1, 32'h8, 32'h0);
        disp(3'b100, 6'd12, 1'b1, 32'h300, 1'b1, 32'h0, 32'h4);
        check("t4_hold0", 105'(en_s), 105'(0));
        step(); check("t4_hold1", 105'(en_s), 105'(0));
        step(); check("t4_hold2", 105'(en_s), 105'(0));
        cdb = {6'd7, 32'h7777};
        step();
`ifdef LOAD_RSV_CDB_FORWARD_EN
        check("t4_a_fwd", 105'(en_s), 105'(1));
        cdb = '0;
`else
        check("t4_a_wait", 105'(en_s), 105'(0));
        cdb = '0;
        step(); check("t4_a_issue", 105'(en_s), 105'(1));
`endif
        step(); check("t4_b_issue", 105'(en_s), 105'(1));
        check("t4_occ", 105'(occupancy), 105'(0));

        // Full, ignored 5th dispatch, out-of-order wakeup, drain in order
        for (int i = 0; i < 4; i++) begin
            sb.push_back(pk(3'b010, 6'(20 + i), 32'(32'h1000 * (i + 1)), 32'h0, 32'(i)));
            disp(3'b010, 6'(20 + i), 1'b0, 32'(10 + i), 1'b1, 32'h0, 32'(i));
        end
        check("t5_full_ready", 105'(dispatch_ready), 105'(0));
        check("t5_full_occ",   105'(occupancy),      105'(4));
        disp(3'b010, 6'd30, 1'b1, 32'hBAD, 1'b1, 32'h0, 32'h0);
        check("t5_ignored_occ", 105'(occupancy), 105'(4));
        for (int i = 3; i >= 0; i--) begin
            cdb = {6'(10 + i), 32'(32'h1000 * (i + 1))};
            step();
        end
        cdb = '0;
        for (int k = 0; k < 12 && occupancy != 0; k++) step();
        check("t5_drain_occ", 105'(occupancy), 105'(0));
        check("t5_drain_sb",  105'(sb.size()), 105'(0));
        for (int i = 0; i < 4; i++) begin
            sb.push_back(pk(3'b101, 6'(40 + i), 32'(32'h500 + i), 32'h40, 32'h8));
            disp(3'b101, 6'(40 + i), 1'b1, 32'(32'h500 + i), 1'b1, 32'h40, 32'h8);
            if (i > 0) check("t5_disp_issue_occ", 105'(occupancy), 105'(1));
        end
        for (int k = 0; k < 8 && occupancy != 0; k++) step();
        check("t5_wrap_occ", 105'(occupancy), 105'(0));
        check("t5_wrap_sb",  105'(sb.size()), 105'(0));

        // Tag-0 broadcast never wakes an operand whose tag field is 0
        disp(3'b010, 6'd50, 1'b0, 32'h0, 1'b1, 32'h0, 32'h0);
        cdb = {6'd0, 32'h5555};
        step(); check("t3_tag0_a", 105'(en_s), 105'(0));
        step(); check("t3_tag0_b", 105'(en_s), 105'(0));
        check("t3_tag0_occ", 105'(occupancy), 105'(1));
        cdb = '0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t3_tag0_flushed", 105'(occupancy), 105'(0));

        // Stall then flush with concurrent dispatch
        issue_stall = 1'b1;
        disp(3'b010, 6'd60, 1'b1, 32'h60, 1'b1, 32'h0, 32'h0);
        disp(3'b010, 6'd61, 1'b1, 32'h61, 1'b1, 32'h0, 32'h0);
        step(); check("t6_stalled", 105'(en_s), 105'(0));
        check("t6_occ2", 105'(occupancy), 105'(2));
        issue_stall = 1'b0;
        flush = 1'b1;
        dispatch_valid = 1'b1; dispatch_dest = 6'd62; dispatch_opr1_rdy = 1'b1; dispatch_opr2_rdy = 1'b1;
        step();
        check("t6_flush_enable", 105'(en_s), 105'(0));
        flush = 1'b0; dispatch_valid = 1'b0;
        check("t6_occ0",   105'(occupancy),      105'(0));
        check("t6_ready",  105'(dispatch_ready), 105'(1));
        check("t6_rs2exe", rs2exe,               105'(0));
        step(); check("t6_none_a", 105'(en_s), 105'(0));
        step(); check("t6_none_b", 105'(en_s), 105'(0));

        check("sb_drained", 105'(sb.size()), 105'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
